tl_burst_arbiter: RTL and testbench



---
 rtl/tl_pkg.sv | 25 ++
 rtl/tl_rr_select.sv | 20 ++
 rtl/tl_burst_arbiter.sv | 118 +++++++++++
 tb/tb_tl_burst_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: TileLink channel types plus the has-data and beat-count helpers used by the arbiters.
package tl_pkg;

    typedef enum logic [2:0] {TL_CHAN_A, TL_CHAN_B, TL_CHAN_C, TL_CHAN_D, TL_CHAN_E} tl_chan_e;

    typedef enum logic {TL_ARB_RR, TL_ARB_FIXED} tl_arb_policy_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic [3:0]  source;
        logic [15:0] data;
    } tl_c_t;

    // A carries data on PutFull/PutPartial; C and D flag data-bearing opcodes with bit 0.
    function automatic logic tl_has_data(input tl_chan_e chan, input logic [2:0] opcode);
        return chan == TL_CHAN_A ? (opcode == 3'd0 || opcode == 3'd1)
                                 : ((chan == TL_CHAN_C || chan == TL_CHAN_D) && opcode[0]);
    endfunction

    function automatic int tl_num_beats(input logic has_data, input int size, input int beat_bytes_log2);
        return (has_data && size > beat_bytes_log2) ? 1 << (size - beat_bytes_log2) : 1;
    endfunction

endpackage

// File: rtl/tl_rr_select.sv
// tl_rr_select: one-hot grant to the first requester at or after ptr, wrapping; ptr tied to 0 gives fixed priority.
module tl_rr_select #(
    parameter int N  = 2,
    parameter int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] rot, pick;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot  = N'({req, req} >> ptr);
        pick = rot & (~rot + N'(1));
        gnt  = N'(({pick, pick} << ptr) >> N);
    end

endmodule

// File: rtl/tl_burst_arbiter.sv
// tl_burst_arbiter: N-to-1 TileLink channel arbiter that locks the output to one master for a whole multi-beat message.
module tl_burst_arbiter
    import tl_pkg::*;
#(
    parameter int             N_MASTER        = 2,
    parameter type            DATA_T          = tl_c_t,
    parameter tl_chan_e       CHANNEL         = TL_CHAN_C,
    parameter int             BEAT_BYTES_LOG2 = 3,
    parameter int             MAX_SIZE        = 6,
    parameter tl_arb_policy_e POLICY          = TL_ARB_RR,
    parameter bit             OUT_REG         = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  DATA_T [N_MASTER-1:0] inp_bits_i,
    input  logic [N_MASTER-1:0]  inp_valid_i,
    output logic [N_MASTER-1:0]  inp_ready_o,
    output DATA_T                oup_bits_o,
    output logic                 oup_valid_o,
    input  logic                 oup_ready_i,
    output logic                 oup_last_o,
    output logic [N_MASTER-1:0]  grant_o,
    output logic                 busy_o
);

    localparam int PW        = N_MASTER > 1 ? $clog2(N_MASTER) : 1;
    localparam int MAX_BEATS = MAX_SIZE > BEAT_BYTES_LOG2 ? 1 << (MAX_SIZE - BEAT_BYTES_LOG2) : 1;
    localparam int CW        = $clog2(MAX_BEATS) + 1;

    typedef enum logic {IDLE, BURST} state_e;

    state_e              state;
    logic [N_MASTER-1:0] grant, eligible, sel;
    logic [PW-1:0]       rr_ptr, win_idx;
    logic [CW-1:0]       cnt;
    logic                gap, sel_valid, stage_ready, hs, in_last;
    DATA_T               sel_bits;
    int                  nb;

    // gap holds off arbitration for the cycle right after a burst ends.
    assign eligible = state == BURST ? grant & inp_valid_i : (gap ? '0 : inp_valid_i);

    tl_rr_select #(.N(N_MASTER)) u_sel (
        .req (eligible),
        .ptr (POLICY == TL_ARB_RR ? rr_ptr : '0),
        .gnt (sel)
    );

    always_comb begin
        sel_bits = '0;
        win_idx  = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (sel[i]) begin
                sel_bits = inp_bits_i[i];
                win_idx  = PW'(i);
            end
        end
    end

    assign sel_valid   = |eligible;
    assign hs          = sel_valid && stage_ready;
    assign nb          = tl_num_beats(tl_has_data(CHANNEL, sel_bits.opcode), int'(sel_bits.size), BEAT_BYTES_LOG2);
    assign in_last     = state == BURST ? cnt == CW'(1) : nb == 1;
    assign inp_ready_o = sel & {N_MASTER{stage_ready}};
    assign grant_o     = grant;
    assign busy_o      = state == BURST;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            grant  <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
            gap    <= 1'b0;
        end else begin
            gap <= 1'b0;
            if (hs && state == IDLE) begin
                if (POLICY == TL_ARB_RR) rr_ptr <= win_idx == PW'(N_MASTER - 1) ? '0 : win_idx + PW'(1);
                if (nb > 1) begin
                    state <= BURST;
                    grant <= sel;
                    cnt   <= CW'(nb - 1);
                end
            end else if (hs) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state <= IDLE;
                    grant <= '0;
                    gap   <= 1'b1;
                end
            end
        end
    end

    if (OUT_REG) begin : g_reg
        logic  full, q_last;
        DATA_T q_bits;
        assign stage_ready = !full || oup_ready_i;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                full <= 1'b0;
            end else if (stage_ready) begin
                full   <= sel_valid;
                q_bits <= sel_bits;
                q_last <= in_last;
            end
        end
        assign oup_valid_o = full;
        assign oup_bits_o  = q_bits;
        assign oup_last_o  = full && q_last;
    end else begin : g_comb
        assign stage_ready = oup_ready_i;
        assign oup_valid_o = sel_valid;
        assign oup_bits_o  = sel_bits;
        assign oup_last_o  = sel_valid && in_last;
    end

endmodule

// File: tb/tb_tl_burst_arbiter.sv
// tb_tl_burst_arbiter: directed checks on three arbiter configurations (3-master RR, 2-master fixed, 2-master registered RR).
module tb_tl_burst_arbiter;
    import tl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    tl_c_t [2:0] b0;
    logic  [2:0] v0, r0, g0;
    tl_c_t       o0;
    logic        ov0, or0, ol0, bz0;

    tl_c_t [1:0] b1;
    logic  [1:0] v1, r1, g1;
    tl_c_t       o1;
    logic        ov1, or1, ol1, bz1;

    tl_c_t [1:0] b2;
    logic  [1:0] v2, r2, g2;
    tl_c_t       o2;
    logic        ov2, or2, ol2, bz2;

    tl_burst_arbiter #(.N_MASTER(3), .DATA_T(tl_c_t), .CHANNEL(TL_CHAN_C), .BEAT_BYTES_LOG2(3),
                       .MAX_SIZE(6), .POLICY(TL_ARB_RR), .OUT_REG(1'b0)) u0 (
        .clk_i(clk), .rst_i(rst), .inp_bits_i(b0), .inp_valid_i(v0), .inp_ready_o(r0),
        .oup_bits_o(o0), .oup_valid_o(ov0), .oup_ready_i(or0), .oup_last_o(ol0),
        .grant_o(g0), .busy_o(bz0));

    tl_burst_arbiter #(.N_MASTER(2), .DATA_T(tl_c_t), .CHANNEL(TL_CHAN_C), .BEAT_BYTES_LOG2(3),
                       .MAX_SIZE(6), .POLICY(TL_ARB_FIXED), .OUT_REG(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst), .inp_bits_i(b1), .inp_valid_i(v1), .inp_ready_o(r1),
        .oup_bits_o(o1), .oup_valid_o(ov1), .oup_ready_i(or1), .oup_last_o(ol1),
        .grant_o(g1), .busy_o(bz1));

    tl_burst_arbiter #(.N_MASTER(2), .DATA_T(tl_c_t), .CHANNEL(TL_CHAN_C), .BEAT_BYTES_LOG2(3),
                       .MAX_SIZE(6), .POLICY(TL_ARB_RR), .OUT_REG(1'b1)) u2 (
        .clk_i(clk), .rst_i(rst), .inp_bits_i(b2), .inp_valid_i(v2), .inp_ready_o(r2),
        .oup_bits_o(o2), .oup_valid_o(ov2), .oup_ready_i(or2), .oup_last_o(ol2),
        .grant_o(g2), .busy_o(bz2));

    function automatic tl_c_t mk(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src, input logic [15:0] d);
        tl_c_t m;
        m.opcode = op;
        m.size   = sz;
        m.source = src;
        m.data   = d;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b0 = '0; v0 = '0; or0 = 1'b1;
        b1 = '0; v1 = '0; or1 = 1'b1;
        b2 = '0; v2 = '0; or2 = 1'b1;
        nxt();
        nxt();
        #3;
        chk("rst_valid", ov0, 0);
        chk("rst_ready", r0, 0);
        chk("rst_grant", g0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_last", ol0, 0);
        chk("rst_reg_valid", ov2, 0);
        chk("rst_reg_last", ol2, 0);
        nxt();
        rst = 1'b0;

        // Single-beat ProbeAcks from masters 0 and 1 alternate under round-robin.
        b0[0] = mk(3'd4, 4'd6, 4'd0, 16'h0010);
        b0[1] = mk(3'd4, 4'd6, 4'd1, 16'h0011);
        v0 = 3'b011;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("alt_ready", r0, (k % 2) ? 3'b010 : 3'b001);
            chk("alt_valid", ov0, 1);
            chk("alt_last", ol0, 1);
            chk("alt_src", o0.source, k % 2);
            chk("alt_busy", bz0, 0);
            nxt();
        end
        v0 = '0;

        // 8-beat ReleaseData from master 1 with downstream ready toggling.
        b0[1] = mk(3'd7, 4'd6, 4'd1, 16'h0071);
        v0 = 3'b010;
        for (int c = 0; c < 15; c++) begin
            or0 = (c % 2 == 0);
            #3;
            chk("tog_ready", r0, or0 ? 3'b010 : 3'b000);
            chk("tog_valid", ov0, 1);
            chk("tog_last", ol0, c >= 13);
            chk("tog_grant", g0, c == 0 ? 3'b000 : 3'b010);
            chk("tog_busy", bz0, c != 0);
            nxt();
        end
        #3;
        chk("tog_end_busy", bz0, 0);
        chk("tog_end_grant", g0, 0);
        chk("tog_bubble", ov0, 0);
        nxt();
        or0 = 1'b0;
        #3;
        chk("tog_rearb_valid", ov0, 1);
        chk("tog_rearb_busy", bz0, 0);
        nxt();
        v0 = '0;
        or0 = 1'b1;

        // Master 2 sends 4 beats, drops valid for 3 cycles after beat 3; master 0 waits.
        b0[0] = mk(3'd4, 4'd6, 4'd0, 16'h0040);
        b0[2] = mk(3'd7, 4'd5, 4'd2, 16'h0072);
        v0 = 3'b101;
        #3;
        chk("stall_b1_ready", r0, 3'b100);
        chk("stall_b1_last", ol0, 0);
        chk("stall_b1_busy", bz0, 0);
        nxt();
        for (int c = 1; c < 3; c++) begin
            #3;
            chk("stall_bn_ready", r0, 3'b100);
            chk("stall_bn_grant", g0, 3'b100);
            chk("stall_bn_last", ol0, 0);
            chk("stall_bn_src", o0.source, 2);
            nxt();
        end
        v0 = 3'b001;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk("stall_gap_valid", ov0, 0);
            chk("stall_gap_ready", r0, 0);
            chk("stall_gap_grant", g0, 3'b100);
            chk("stall_gap_busy", bz0, 1);
            nxt();
        end
        v0 = 3'b101;
        #3;
        chk("stall_b4_ready", r0, 3'b100);
        chk("stall_b4_last", ol0, 1);
        nxt();
        #3;
        chk("stall_bubble", ov0, 0);
        chk("stall_end_busy", bz0, 0);
        nxt();
        #3;
        chk("stall_next_ready", r0, 3'b001);
        chk("stall_next_src", o0.source, 0);
        chk("stall_next_last", ol0, 1);
        nxt();
        v0 = '0;

        // Reset during beat 5 of 8 abandons the burst.
        b0[0] = mk(3'd7, 4'd6, 4'd0, 16'h0050);
        v0 = 3'b001;
        for (int c = 0; c < 4; c++) begin
            #3;
            chk("rstb_ready", r0, 3'b001);
            nxt();
        end
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        b0[1] = mk(3'd4, 4'd6, 4'd1, 16'h0051);
        v0 = 3'b010;
        #3;
        chk("rstb_grant", g0, 0);
        chk("rstb_busy", bz0, 0);
        chk("rstb_new_ready", r0, 3'b010);
        chk("rstb_new_valid", ov0, 1);
        chk("rstb_new_last", ol0, 1);
        nxt();
        v0 = '0;

        // Fixed priority: master 1 wins first, master 0 arrives mid-burst and must wait.
        b1[1] = mk(3'd7, 4'd6, 4'd1, 16'h0061);
        v1 = 2'b10;
        #3;
        chk("fx_first_ready", r1, 2'b10);
        chk("fx_first_busy", bz1, 0);
        nxt();
        b1[0] = mk(3'd7, 4'd2, 4'd0, 16'h0060);
        v1 = 2'b11;
        for (int c = 1; c < 8; c++) begin
            #3;
            chk("fx_ready", r1, 2'b10);
            chk("fx_last", ol1, c == 7);
            chk("fx_src", o1.source, 1);
            chk("fx_busy", bz1, 1);
            nxt();
        end
        v1 = 2'b01;
        #3;
        chk("fx_bubble_valid", ov1, 0);
        chk("fx_bubble_ready", r1, 0);
        chk("fx_bubble_busy", bz1, 0);
        nxt();
        #3;
        chk("fx_m0_ready", r1, 2'b01);
        chk("fx_m0_last", ol1, 1);
        chk("fx_m0_data", o1.data, 16'h0060);
        nxt();
        #3;
        chk("fx_small_busy", bz1, 0);
        chk("fx_small_valid", ov1, 1);
        nxt();
        v1 = '0;

        // Registered output: one-cycle latency, one message per cycle, order preserved.
        v2 = 2'b01;
        for (int k = 0; k < 5; k++) begin
            b2[0] = mk(3'd4, 4'd6, 4'd0, 16'h00A0 + 16'(k));
            #3;
            chk("reg_ready", r2, 2'b01);
            chk("reg_valid", ov2, k > 0);
            if (k > 0) begin
                chk("reg_data", o2.data, 16'h00A0 + 16'(k - 1));
                chk("reg_last", ol2, 1);
            end
            nxt();
        end
        v2 = '0;
        #3;
        chk("reg_drain_valid", ov2, 1);
        chk("reg_drain_data", o2.data, 16'h00A4);
        nxt();
        #3;
        chk("reg_empty", ov2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
